// File: rtl/sync_sequencer.sv
// Arm / fire / wire-contact / trigger sequencer for the synchronization block.
// Inputs are synchronized here; all outputs come straight from flops.
module sync_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 24,
  parameter int DET_DELAY    = 240_000,
  parameter int DET_WIDTH    = 500,
  parameter int DEBOUNCE     = 50,
  parameter int WIRE_TIMEOUT = 100_000,
  parameter int TRIG_WIDTH   = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       fg_opto,
  input  logic       wire_sensor,
  input  logic       detector_ready,
  output logic       detonator_triggered,
  output logic       output_trigger,
  output logic       busy,
  output logic [2:0] state,
  output logic [1:0] error
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    DET_WAIT  = 3'd2,
    DET_FIRE  = 3'd3,
    WIRE_WAIT = 3'd4,
    TRIG      = 3'd5,
    HOLD      = 3'd6
  } state_t;

  localparam logic [CNT_W:0]   DELAY_END   = (CNT_W+1)'(DET_DELAY);
  localparam logic [CNT_W:0]   WIDTH_END   = (CNT_W+1)'(DET_WIDTH);
  localparam logic [CNT_W:0]   TIMEOUT_END = (CNT_W+1)'(WIRE_TIMEOUT);
  localparam logic [CNT_W:0]   TRIG_END    = (CNT_W+1)'(TRIG_WIDTH);
  localparam logic [CNT_W-1:0] DEB_END     = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] start_sync_r;
  logic [SYNC_STAGES-1:0] fg_sync_r;
  logic [SYNC_STAGES-1:0] wire_sync_r;
  logic [SYNC_STAGES-1:0] ready_sync_r;
  logic                   start_prev_r;
  logic                   fg_prev_r;

  logic                   start_rise_s;
  logic                   fg_rise_s;
  logic                   wire_lvl_s;
  logic                   ready_lvl_s;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W:0]         cnt_plus_s;
  logic                   cnt_clear_s;
  logic [CNT_W-1:0]       deb_r;
  logic                   deb_done_s;
  logic                   fell_r;
  logic                   fell_next_s;
  logic [1:0]             err_r;
  logic [1:0]             err_next_s;
  logic                   det_r;
  logic                   trig_r;
  logic                   busy_r;

  // Synchronizer chains plus the previous synchronized level for edge detection
  always_ff @(posedge clock) begin
    if (!reset) begin
      start_sync_r <= {SYNC_STAGES{1'b0}};
      fg_sync_r    <= {SYNC_STAGES{1'b0}};
      wire_sync_r  <= {SYNC_STAGES{1'b0}};
      ready_sync_r <= {SYNC_STAGES{1'b0}};
      start_prev_r <= 1'b0;
      fg_prev_r    <= 1'b0;
    end else begin
      start_sync_r <= {start_sync_r[SYNC_STAGES-2:0], start};
      fg_sync_r    <= {fg_sync_r[SYNC_STAGES-2:0], fg_opto};
      wire_sync_r  <= {wire_sync_r[SYNC_STAGES-2:0], wire_sensor};
      ready_sync_r <= {ready_sync_r[SYNC_STAGES-2:0], detector_ready};
      start_prev_r <= start_sync_r[SYNC_STAGES-1];
      fg_prev_r    <= fg_sync_r[SYNC_STAGES-1];
    end
  end

  assign start_rise_s = start_sync_r[SYNC_STAGES-1] & ~start_prev_r;
  assign fg_rise_s    = fg_sync_r[SYNC_STAGES-1] & ~fg_prev_r;
  assign wire_lvl_s   = wire_sync_r[SYNC_STAGES-1];
  assign ready_lvl_s  = ready_sync_r[SYNC_STAGES-1];

  // cnt_plus is one bit wider so the end compares stay exact even when saturated
  assign cnt_plus_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
  assign deb_done_s = (deb_r >= DEB_END);

  // Next-state, counter-clear, error and HOLD sub-phase decisions
  always_comb begin
    state_next_s = state_r;
    err_next_s   = err_r;
    fell_next_s  = fell_r;
    cnt_clear_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_rise_s) begin
          if (ready_lvl_s) begin
            state_next_s = ARMED;
            err_next_s   = 2'd0;
          end else begin
            err_next_s   = 2'd1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ARMED: begin
        if (fg_rise_s) begin
          state_next_s = DET_WAIT;
          cnt_clear_s  = 1'b1;
        end else begin
          state_next_s = ARMED;
        end
      end
      DET_WAIT: begin
        if (cnt_plus_s == DELAY_END) begin
          state_next_s = DET_FIRE;
          cnt_clear_s  = 1'b1;
        end else begin
          state_next_s = DET_WAIT;
        end
      end
      DET_FIRE: begin
        if (cnt_plus_s == WIDTH_END) begin
          state_next_s = WIRE_WAIT;
        end else begin
          state_next_s = DET_FIRE;
        end
      end
      WIRE_WAIT: begin
        if (deb_done_s) begin
          state_next_s = TRIG;
          cnt_clear_s  = 1'b1;
        end else if (cnt_plus_s >= TIMEOUT_END) begin
          state_next_s = IDLE;
          err_next_s   = 2'd2;
        end else begin
          state_next_s = WIRE_WAIT;
        end
      end
      TRIG: begin
        if (cnt_plus_s == TRIG_END) begin
          state_next_s = HOLD;
          fell_next_s  = 1'b0;
        end else begin
          state_next_s = TRIG;
        end
      end
      HOLD: begin
        if (!fell_r) begin
          if (!ready_lvl_s) begin
            fell_next_s = 1'b1;
          end else begin
            fell_next_s = 1'b0;
          end
        end else if (ready_lvl_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    if ((state_next_s == IDLE) || (state_next_s == ARMED)) begin
      cnt_clear_s = 1'b1;
    end else begin
      cnt_clear_s = cnt_clear_s;
    end
  end

  // Shared saturating delay counter and wire-contact debounce counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
      deb_r <= {CNT_W{1'b0}};
    end else begin
      if (cnt_clear_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if ((state_r == WIRE_WAIT) && wire_lvl_s) begin
        deb_r <= (deb_r != CNT_MAX) ? (deb_r + CNT_ONE) : deb_r;
      end else begin
        deb_r <= {CNT_W{1'b0}};
      end
    end
  end

  // State register and outputs, decoded from the next state so they align with it
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
      fell_r  <= 1'b0;
      err_r   <= 2'd0;
      det_r   <= 1'b0;
      trig_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      fell_r  <= fell_next_s;
      err_r   <= err_next_s;
      det_r   <= (state_next_s == DET_FIRE);
      trig_r  <= (state_next_s == TRIG);
      busy_r  <= (state_next_s != IDLE);
    end
  end

  assign detonator_triggered = det_r;
  assign output_trigger      = trig_r;
  assign busy                = busy_r;
  assign state               = state_r;
  assign error               = err_r;

endmodule

// File: tb/tb_sync_sequencer.sv
// Bench for sync_sequencer: event-time reference model compared every cycle,
// directed scenarios with hand-computed latencies, then randomized stimulus.
module tb_sync_sequencer;

  localparam int SYNC_STAGES  = 2;
  localparam int CNT_W        = 24;
  localparam int DET_DELAY    = 100;
  localparam int DET_WIDTH    = 20;
  localparam int DEBOUNCE     = 5;
  localparam int WIRE_TIMEOUT = 1000;
  localparam int TRIG_WIDTH   = 50;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_DWAIT = 2;
  localparam int P_FIRE  = 3;
  localparam int P_WIRE  = 4;
  localparam int P_TRIG  = 5;
  localparam int P_HOLD  = 6;

  logic       clock;
  logic       reset;
  logic       start;
  logic       fg_opto;
  logic       wire_sensor;
  logic       detector_ready;
  logic       detonator_triggered;
  logic       output_trigger;
  logic       busy;
  logic [2:0] state;
  logic [1:0] error;

  sync_sequencer #(
    .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .DET_DELAY(DET_DELAY),
    .DET_WIDTH(DET_WIDTH), .DEBOUNCE(DEBOUNCE), .WIRE_TIMEOUT(WIRE_TIMEOUT),
    .TRIG_WIDTH(TRIG_WIDTH)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .fg_opto(fg_opto),
    .wire_sensor(wire_sensor), .detector_ready(detector_ready),
    .detonator_triggered(detonator_triggered), .output_trigger(output_trigger),
    .busy(busy), .state(state), .error(error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: phase plus absolute deadlines in clock-edge numbers
  int m_phase, m_err, m_run, fire_at, fire_end, tmo_at, trig_end;
  bit m_fell;
  bit ln_start[SYNC_STAGES];
  bit ln_fg[SYNC_STAGES];
  bit ln_wire[SYNC_STAGES];
  bit ln_ready[SYNC_STAGES];
  bit pv_start, pv_fg;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit s_start, s_fg, s_wire, s_ready;
    int old_phase;
    if (!reset) begin
      m_phase = P_IDLE; m_err = 0; m_run = 0; m_fell = 1'b0;
      pv_start = 1'b0; pv_fg = 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ln_start[i] = 1'b0; ln_fg[i] = 1'b0; ln_wire[i] = 1'b0; ln_ready[i] = 1'b0;
      end
    end else begin
      s_start = ln_start[SYNC_STAGES-1];
      s_fg    = ln_fg[SYNC_STAGES-1];
      s_wire  = ln_wire[SYNC_STAGES-1];
      s_ready = ln_ready[SYNC_STAGES-1];
      old_phase = m_phase;
      case (m_phase)
        P_IDLE:
          if (s_start && !pv_start) begin
            if (s_ready) begin m_phase = P_ARMED; m_err = 0; end
            else m_err = 1;
          end
        P_ARMED:
          if (s_fg && !pv_fg) begin m_phase = P_DWAIT; fire_at = cyc + DET_DELAY; end
        P_DWAIT:
          if (cyc == fire_at) begin
            m_phase = P_FIRE; fire_end = cyc + DET_WIDTH; tmo_at = cyc + WIRE_TIMEOUT;
          end
        P_FIRE:
          if (cyc == fire_end) m_phase = P_WIRE;
        P_WIRE:
          if (m_run >= DEBOUNCE) begin m_phase = P_TRIG; trig_end = cyc + TRIG_WIDTH; end
          else if (cyc >= tmo_at) begin m_phase = P_IDLE; m_err = 2; end
        P_TRIG:
          if (cyc == trig_end) begin m_phase = P_HOLD; m_fell = 1'b0; end
        P_HOLD:
          if (!m_fell) begin if (!s_ready) m_fell = 1'b1; end
          else if (s_ready) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
      m_run = (old_phase == P_WIRE && s_wire) ? m_run + 1 : 0;
      pv_start = s_start;
      pv_fg    = s_fg;
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        ln_start[i] = ln_start[i-1]; ln_fg[i] = ln_fg[i-1];
        ln_wire[i]  = ln_wire[i-1];  ln_ready[i] = ln_ready[i-1];
      end
      ln_start[0] = start; ln_fg[0] = fg_opto; ln_wire[0] = wire_sensor; ln_ready[0] = detector_ready;
    end
  endtask

  task automatic compare();
    check("state", int'(state), m_phase);
    check("busy", int'(busy), int'(m_phase != P_IDLE));
    check("detonator", int'(detonator_triggered), int'(m_phase == P_FIRE));
    check("trigger", int'(output_trigger), int'(m_phase == P_TRIG));
    check("error", int'(error), m_err);
    check("exclusive", int'(detonator_triggered && output_trigger), 0);
  endtask

  // One clock: model advances on the edge, DUT outputs compared on the falling edge
  task automatic tick();
    @(posedge clock);
    cyc++;
    model_step();
    @(negedge clock);
    compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic bit sig(input int which);
    if (which == 0) return detonator_triggered;
    else return output_trigger;
  endfunction

  task automatic wait_high(input string name, input int which, input int budget, output int t);
    t = -1;
    for (int i = 0; i <= budget && t < 0; i++) begin
      if (sig(which)) t = cyc;
      else tick();
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL %s never rose within %0d cycles", name, budget);
    end
  endtask

  task automatic measure_width(input int which, output int w);
    w = 0;
    while (sig(which) && w < 2000) begin
      w++;
      tick();
    end
  endtask

  task automatic arm();
    start = 1'b1; ticks(4);
    start = 1'b0; ticks(2);
  endtask

  task automatic fire_run(output int t);
    int c0;
    fg_opto = 1'b0; ticks(3);
    fg_opto = 1'b1; c0 = cyc;
    wait_high("detonator", 0, 300, t);
    check("fire_latency", t - c0, SYNC_STAGES + 1 + DET_DELAY);
  endtask

  task automatic hold_exit();
    detector_ready = 1'b0; ticks(5);
    detector_ready = 1'b1; ticks(5);
  endtask

  initial begin
    int t, t2, w, c1, seen, wmode;
    reset = 1'b0; start = 1'b0; fg_opto = 1'b0; wire_sensor = 1'b0; detector_ready = 1'b1;
    ticks(3);
    check("reset_state", int'(state), 0);
    check("reset_error", int'(error), 0);
    check("reset_outputs", int'({detonator_triggered, output_trigger, busy}), 0);
    reset = 1'b1; ticks(3);

    // Nominal run
    arm();
    check("armed_state", int'(state), P_ARMED);
    fire_run(t);
    measure_width(0, w);
    check("det_width", w, DET_WIDTH);
    wire_sensor = 1'b1; c1 = cyc;
    wait_high("trigger", 1, 50, t2);
    check("trig_latency", t2 - c1, SYNC_STAGES + DEBOUNCE + 1);
    measure_width(1, w);
    check("trig_width", w, TRIG_WIDTH);
    check("hold_state", int'(state), P_HOLD);
    wire_sensor = 1'b0;
    hold_exit();
    check("back_idle", int'(state), P_IDLE);

    // Bounce rejection
    arm();
    fire_run(t);
    measure_width(0, w);
    for (int k = 0; k < 10; k++) begin
      wire_sensor = 1'b1; ticks($urandom_range(1, 4));
      wire_sensor = 1'b0; ticks($urandom_range(1, 3));
    end
    check("bounce_state", int'(state), P_WIRE);
    wire_sensor = 1'b1; c1 = cyc;
    wait_high("trigger_after_bounce", 1, 50, t2);
    check("bounce_trig_latency", t2 - c1, SYNC_STAGES + DEBOUNCE + 1);
    measure_width(1, w);
    wire_sensor = 1'b0;
    hold_exit();

    // Wire timeout
    arm();
    fire_run(t);
    seen = 0;
    while (error == 2'd0 && cyc < t + 1100) begin
      if (output_trigger) seen = 1;
      tick();
    end
    check("timeout_cycles", cyc - t, WIRE_TIMEOUT);
    check("timeout_error", int'(error), 2);
    check("timeout_state", int'(state), P_IDLE);
    check("timeout_no_trig", seen, 0);

    // Detector not ready, then a good arm
    detector_ready = 1'b0; ticks(3);
    start = 1'b1; ticks(6);
    check("notready_error", int'(error), 1);
    check("notready_busy", int'(busy), 0);
    start = 1'b0; detector_ready = 1'b1; ticks(4);
    start = 1'b1; ticks(4);
    check("rearm_state", int'(state), P_ARMED);
    check("rearm_error", int'(error), 0);
    start = 1'b0;

    // Reset in the 10th detonator cycle
    fire_run(t);
    ticks(9);
    reset = 1'b0; tick();
    check("rst_outputs", int'({detonator_triggered, output_trigger, busy}), 0);
    check("rst_state", int'(state), 0);
    reset = 1'b1;
    fg_opto = 1'b0; ticks(3);
    fg_opto = 1'b1;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      if (detonator_triggered || state != 3'd0) seen = 1;
      tick();
    end
    check("no_fire_unarmed", seen, 0);

    // Spurious fg_opto during DET_WAIT and start during HOLD
    fg_opto = 1'b0;
    arm();
    fg_opto = 1'b1; c1 = cyc;
    ticks(20); fg_opto = 1'b0; ticks(5); fg_opto = 1'b1;
    wait_high("detonator_spurious", 0, 300, t);
    check("spurious_fire_time", t - c1, SYNC_STAGES + 1 + DET_DELAY);
    measure_width(0, w);
    wire_sensor = 1'b1;
    wait_high("trigger_spurious", 1, 50, t2);
    measure_width(1, w);
    start = 1'b1; ticks(5); start = 1'b0;
    hold_exit();
    ticks(20);
    check("no_rearm_state", int'(state), P_IDLE);
    check("no_rearm_busy", int'(busy), 0);
    wire_sensor = 1'b0; fg_opto = 1'b0;

    // Randomized stimulus
    wmode = 0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 99) < 2) start = ~start;
      if ($urandom_range(0, 99) < 2) fg_opto = ~fg_opto;
      if ($urandom_range(0, 199) < 1) detector_ready = ~detector_ready;
      if (i % 64 == 0) wmode = $urandom_range(0, 2);
      case (wmode)
        0: wire_sensor = 1'b0;
        1: wire_sensor = 1'b1;
        default: wire_sensor = 1'($urandom_range(0, 1));
      endcase
      reset = ($urandom_range(0, 1999) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
